mdu_ctrl: RTL
=============

// Module: mdu_ctrl
// PURPOSE
//  Multi-cycle multiply/divide unit sequencer beside the EX-stage ALU; owns HI/LO.
//  Accepts one MDU op per start pulse, holds busy for a fixed latency, then commits HI/LO.
//  The hazard unit stalls D-stage MDU instructions while (start | busy).
//  mfhi/mflo read HI/LO combinationally through rd_data.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (and madd/maddu/msub/msubu when enabled); legal range 1..15
//  DIV_CYCLES   10  busy cycles for div/divu; legal range 1..15
// PORTS
//  clk      in   1   clock, rising edge
//  reset    in   1   asynchronous, active-low reset
//  start    in   1   issue mdu_op this cycle (ignored unless mdu_op is mult/div class)
//  mdu_op   in   4   0000 nop, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo,
//                    0111 madd, 1000 maddu, 1001 msub, 1010 msubu (0111-1010 need macro)
//  A        in   32  rs operand / dividend / mthi-mtlo source
//  B        in   32  rt operand / divisor
//  rd_hi    in   1   1: rd_data=HI, 0: rd_data=LO
//  busy     out  1   operation in flight
//  hi       out  32  HI register
//  lo       out  32  LO register
//  rd_data  out  32  rd_hi ? hi : lo, combinational, valid every cycle
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, count=0, busy=0, hi=0, lo=0; any in-flight op is discarded.
//  States: IDLE, BUSY. 4-bit down-counter count.
//  IDLE, start=1, mult/div-class op at edge T: A, B, op latched; count<=N
//    (N=MULT_CYCLES or DIV_CYCLES); state<=BUSY. busy=1 for cycles T+1..T+N.
//  BUSY: count decrements each edge; at the edge where count==1, hi/lo commit, state<=IDLE;
//    new values visible and busy=0 from cycle T+N+1. Back-to-back start allowed that cycle.
//  start while BUSY: ignored, no state change (hazard unit must prevent it).
//  mthi/mtlo (mdu_op 0101/0110): single-cycle write of A into hi/lo at the edge, only when
//    state=IDLE; start not required; ignored while BUSY. Busy stays 0.
//  nop or unknown op: no effect.
//  Arithmetic: mult = signed 32x32->64, multu unsigned; {hi,lo}=product.
//    div: lo=signed quotient truncated toward zero, hi=remainder with sign of dividend;
//    divu unsigned. Divisor==0: op still takes DIV_CYCLES busy, hi/lo left unchanged.
//    div 0x80000000 / -1: lo=0x80000000, hi=0.
//  Result may be computed at the latch edge or over the busy window; only the commit edge
//    may change hi/lo. hi/lo never show intermediate values.
// CONFIGURATION
//  MDU_MADD_EN defined: ops 0111-1010 accepted with MULT_CYCLES latency;
//    madd {hi,lo}+=A*B signed, maddu unsigned, msub {hi,lo}-=A*B signed, msubu unsigned;
//    the accumulate base is the {hi,lo} value at commit, modulo 2^64.
//  MDU_MADD_EN undefined: ops 0111-1010 treated as nop (no busy, no hi/lo change).
// TESTING
//  mult A=0xFFFFFFFD(-3) B=5 -> busy exactly 5 cycles; hi=0xFFFFFFFF lo=0xFFFFFFF1 at T+6.
//  divu 7/2 then div 0xFFFFFFF9/2 back-to-back -> lo=3 hi=1, then lo=0xFFFFFFFD hi=0xFFFFFFFF; 10 busy cycles each.
//  mthi 0x12345678, div A=9 B=0 -> 10 busy cycles; hi=0x12345678, lo unchanged.
//  mult in flight; mtlo 0xAA and second start mid-busy -> both ignored; lo=product at commit.
//  reset=0 at cycle T+2 of div -> busy, hi, lo = 0 immediately; no later commit.
//  MDU_MADD_EN: mthi 0, mtlo 1, madd 2*3 -> hi=0 lo=7; msubu 1*8 -> {hi,lo}=0xFFFFFFFF_FFFFFFFF.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer that owns HI/LO: one op per start pulse, fixed busy latency, then commit.
// Optional macro MDU_MADD_EN enables madd/maddu/msub/msubu with MULT_CYCLES latency.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MADDU = 4'b1000;
  localparam logic [3:0] OP_MSUB  = 4'b1001;
  localparam logic [3:0] OP_MSUBU = 4'b1010;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;

  logic        is_mult, is_div;
  logic [63:0] prod_s, prod_u;
  logic [31:0] res_hi, res_lo;
  logic        commit_ok;

`ifdef MDU_MADD_EN
  assign is_mult = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                   (mdu_op == OP_MADD) || (mdu_op == OP_MADDU) ||
                   (mdu_op == OP_MSUB) || (mdu_op == OP_MSUBU);
`else
  assign is_mult = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`endif
  assign is_div  = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Result is formed from the latched operands and applied only on the commit edge,
  // so hi/lo never expose partial values and accumulates see hi/lo as of commit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    res_hi    = hi;
    res_lo    = lo;
    commit_ok = 1'b1;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (b_q == 32'd0) begin
          commit_ok = 1'b0;
        end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $signed(a_q) / $signed(b_q);
          res_hi = $signed(a_q) % $signed(b_q);
        end
      end
      OP_DIVU: begin
        if (b_q == 32'd0) begin
          commit_ok = 1'b0;
        end else begin
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
      OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
      OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
      OP_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
      default:  commit_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state <= IDLE;
      count <= 4'd0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (is_mult || is_div)) begin
            op_q  <= mdu_op;
            a_q   <= A;
            b_q   <= B;
            count <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy  <= 1'b1;
            state <= BUSY;
          end else if (mdu_op == OP_MTHI) begin
            hi <= A;
          end else if (mdu_op == OP_MTLO) begin
            lo <= A;
          end
        end
        BUSY: begin
          if (count == 4'd1) begin
            if (commit_ok) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            count <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data = rd_hi ? hi : lo;

endmodule
